wr_ctrl_pgen: RTL and testbench

- Second-generation write-side controller for the dual-clock FIFO; lives entirely in the w_clk domain.
- Tracks the write pointer and publishes a registered, glitch-free Gray pointer for crossing into the read domain.
- Takes the read pointer as a Gray code that has already been synchronised into w_clk.
- Adds same-cycle full detection, a programmable almost-full flag, a free-slot count and overflow error capture.

---
 rtl/wr_ctrl_pgen_if.sv | 47 ++++
 rtl/wr_ctrl_pgen.sv | 126 ++++++++++++
 tb/tb_wr_ctrl_pgen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wr_ctrl_pgen_if.sv
// Write-side bus of the dual-clock FIFO controller.
// Groups the producer request, the synchronised read pointer and every
// status output of wr_ctrl_pgen so they travel as one port.
// The master modport is the producer/testbench side, the slave modport is
// the controller itself.
interface wr_ctrl_pgen_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  winc;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  w_ovf_clr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   w_ptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wfree;
  logic                  w_ovf;

  modport master (
    output winc,
    output r_ptr,
    output w_ovf_clr,
    input  wen,
    input  waddr,
    input  w_ptr,
    input  wfull,
    input  walmost_full,
    input  wfree,
    input  w_ovf
  );

  modport slave (
    input  winc,
    input  r_ptr,
    input  w_ovf_clr,
    output wen,
    output waddr,
    output w_ptr,
    output wfull,
    output walmost_full,
    output wfree,
    output w_ovf
  );

endinterface

// File: rtl/wr_ctrl_pgen.sv
// wr_ctrl_pgen: write-side controller of the dual-clock FIFO (w_clk domain).
// Keeps the binary write pointer, publishes a registered Gray copy for the
// read domain, and derives full / almost-full / free-slot status from the
// already-synchronised Gray read pointer, all with zero lag on the write
// that fills the last slot.
// Optional feature: define WR_CTRL_OVF_STICKY_EN to build the sticky
// overflow flag w_ovf (set on a write attempt while full, cleared by
// w_ovf_clr, set wins). Without it w_ovf is a constant 0.
// Reset w_rst is synchronous and active-low.
module wr_ctrl_pgen #(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 2
) (
  input  logic w_clk,
  input  logic w_rst,
  wr_ctrl_pgen_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_V   = PW'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_THR = PW'(AFULL_LEVEL);

  // Registered state
  logic [ADDR_WIDTH:0] bn_q;
  logic [ADDR_WIDTH:0] w_ptr_q;
  logic                wfull_q;
  logic                afull_q;
  logic [ADDR_WIDTH:0] wfree_q;

  // Next-state values
  logic                accept;
  logic [ADDR_WIDTH:0] bn_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] r_bin;
  logic [ADDR_WIDTH:0] used_next;
  logic [ADDR_WIDTH:0] free_next;
  logic [ADDR_WIDTH:0] full_pattern;
  logic                full_next;
  logic                afull_next;

  // Write acceptance, next pointer and its Gray image
  always_comb begin
    accept    = bus.winc & ~wfull_q;
    bn_next   = bn_q + {{ADDR_WIDTH{1'b0}}, accept};
    gray_next = bn_next ^ (bn_next >> 1);
  end

  // Gray-to-binary decode of the synchronised read pointer
  always_comb begin
    r_bin = '0;
    r_bin[ADDR_WIDTH] = bus.r_ptr[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      r_bin[i] = r_bin[i+1] ^ bus.r_ptr[i];
    end
  end

  // Occupancy and status flags for the next edge; full is compared in Gray
  // space so a pointer exactly one lap ahead of the reader reads as full
  always_comb begin
    used_next    = bn_next - r_bin;
    free_next    = DEPTH_V - used_next;
    full_pattern = {~bus.r_ptr[ADDR_WIDTH:ADDR_WIDTH-1], bus.r_ptr[ADDR_WIDTH-2:0]};
    full_next    = (gray_next == full_pattern);
    afull_next   = (free_next <= AFULL_THR);
  end

  // Pointer and status registers; reset drops any write in the same cycle
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      bn_q    <= '0;
      w_ptr_q <= '0;
      wfull_q <= 1'b0;
      afull_q <= 1'b0;
      wfree_q <= DEPTH_V;
    end else begin
      bn_q    <= bn_next;
      w_ptr_q <= gray_next;
      wfull_q <= full_next;
      afull_q <= afull_next;
      wfree_q <= free_next;
    end
  end

`ifdef WR_CTRL_OVF_STICKY_EN
  logic ovf_q;

  // Sticky overflow: a write attempt while full sets it, clear only wins
  // when no new overflow happens in the same cycle
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      ovf_q <= 1'b0;
    end else if (bus.winc && wfull_q) begin
      ovf_q <= 1'b1;
    end else if (bus.w_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.w_ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.w_ovf_clr;
  assign bus.w_ovf      = 1'b0;
`endif

  assign bus.wen          = accept;
  assign bus.waddr        = bn_q[ADDR_WIDTH-1:0];
  assign bus.w_ptr        = w_ptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = afull_q;
  assign bus.wfree        = wfree_q;

  // Full and zero free slots must always agree, and an empty-slot count of
  // zero must also show as almost full
  a_full_free : assert property (@(posedge w_clk) disable iff (!w_rst)
    wfull_q == (wfree_q == '0));

  a_free_afull : assert property (@(posedge w_clk) disable iff (!w_rst)
    (wfree_q == '0) |-> afull_q);

  // Outside of reset the published Gray pointer moves by at most one bit
  a_gray_step : assert property (@(posedge w_clk) disable iff (!w_rst)
    $past(w_rst) |-> ($countones(w_ptr_q ^ $past(w_ptr_q)) <= 1));

endmodule

// File: tb/tb_wr_ctrl_pgen.sv
// Testbench for wr_ctrl_pgen (ADDR_WIDTH=4, AFULL_LEVEL=2).
// The reference model tracks total writes and reads as plain integers and
// derives every expected output from their difference; the read side is
// emulated by advancing a read count and driving its Gray code on r_ptr.
// Define WR_CTRL_OVF_STICKY_EN here too when building the DUT with it.
module tb_wr_ctrl_pgen;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 2;

  logic w_clk;
  logic w_rst;

  wr_ctrl_pgen_if #(.ADDR_WIDTH(AW)) bus ();

  wr_ctrl_pgen #(
    .ADDR_WIDTH (AW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .bus  (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model state
  int mWr   = 0;
  int mRd   = 0;
  bit mFull = 1'b0;
  bit mAfull = 1'b0;
  int mFree = DEPTH;
  bit mOvf  = 1'b0;

  function automatic logic [AW:0] toGray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One w_clk cycle: drive inputs, check combinational outputs, clock,
  // advance the model, then check all registered outputs
  task automatic applyStimulus(input bit rstN, input bit inc, input int rdStep,
                               input bit clr);
    bit willAccept;
    int occ;
    if (!rstN) mRd = 0;
    else       mRd = mRd + rdStep;
    w_rst         = rstN;
    bus.winc      = inc;
    bus.w_ovf_clr = clr;
    bus.r_ptr     = toGray(mRd);
    #1;
    checkOutput("wen",   32'(bus.wen),   32'(inc && !mFull));
    checkOutput("waddr", 32'(bus.waddr), 32'(mWr % DEPTH));
    @(posedge w_clk);
    if (!rstN) begin
      mWr = 0; mFull = 0; mAfull = 0; mFree = DEPTH; mOvf = 0;
    end else begin
      willAccept = inc && !mFull;
`ifdef WR_CTRL_OVF_STICKY_EN
      if (inc && mFull) mOvf = 1'b1;
      else if (clr)     mOvf = 1'b0;
`endif
      if (willAccept) mWr++;
      occ    = mWr - mRd;
      mFull  = (occ == DEPTH);
      mFree  = DEPTH - occ;
      mAfull = (mFree <= AFULL);
    end
    #1;
    checkOutput("w_ptr",        32'(bus.w_ptr),        32'(toGray(mWr)));
    checkOutput("wfull",        32'(bus.wfull),        32'(mFull));
    checkOutput("wfree",        32'(bus.wfree),        32'(mFree));
    checkOutput("walmost_full", 32'(bus.walmost_full), 32'(mAfull));
    checkOutput("w_ovf",        32'(bus.w_ovf),        32'(mOvf));
  endtask

  initial begin
    int avail;
    int step;
    w_rst         = 1'b0;
    bus.winc      = 1'b0;
    bus.w_ovf_clr = 1'b0;
    bus.r_ptr     = '0;

    // Reset for two edges
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_wfree", 32'(bus.wfree), 32'd16);

    // Fill: 16 accepted writes, then one refused
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1, 0, 0);
      if (i == 14) checkOutput("afull_at_14", 32'(bus.walmost_full), 32'd1);
      if (i == 15) checkOutput("notfull_at_15", 32'(bus.wfull), 32'd0);
    end
    checkOutput("full_at_16", 32'(bus.wfull), 32'd1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("hold_waddr", 32'(bus.waddr), 32'd0);

    // Overflow while full, clear, then clear racing a new overflow
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0);

    // Drain four and wrap the pointer to 20
    applyStimulus(1, 0, 4, 0);
    checkOutput("drain_wfree", 32'(bus.wfree), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("wrap_w_ptr", 32'(bus.w_ptr), 32'b11110);
    checkOutput("wrap_full",  32'(bus.wfull), 32'd1);

    // Simultaneous write and read advance keeps wfree at 5
    applyStimulus(1, 0, 5, 0);
    checkOutput("pre_sim_wfree", 32'(bus.wfree), 32'd5);
    applyStimulus(1, 1, 1, 0);
    checkOutput("sim_wfree", 32'(bus.wfree), 32'd5);

    // Reset in the middle of a fill, with a write pending
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("midrst_w_ptr", 32'(bus.w_ptr), 32'd0);
    applyStimulus(1, 1, 0, 0);

    // Randomised traffic with legal read-pointer advances
    for (int i = 0; i < 800; i++) begin
      avail = mWr - mRd;
      step  = (avail > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, (avail < 4) ? avail : 4)) : 0;
      if ($urandom_range(0, 99) == 0)
        applyStimulus(0, $urandom_range(0, 1), 0, 0);
      else
        applyStimulus(1, ($urandom_range(0, 3) != 0), step, ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
